// File: rtl/simt_warp_scheduler_pkg.sv
// Shared GPU core types: warp geometry and per-warp scheduling state.
package pkg_opengpu;
  localparam int WARP_ID_WIDTH = 2;
  localparam int WARP_SIZE = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    INACTIVE = 2'd0,
    READY    = 2'd1,
    PENDING  = 2'd2
  } warp_state_t;
endpackage

// File: rtl/simt_warp_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr wins.
module rr_arbiter #(
  parameter int W = 4,
  parameter int IDW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [W-1:0]   gnt,
  output logic [IDW-1:0] id,
  output logic           any
);
  int idx;

  always_comb begin
    gnt = '0;
    id = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 1; i <= W; i++) begin
      idx = (int'(ptr) + i) % W;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        id = IDW'(idx);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/simt_warp_scheduler.sv
// Round-robin warp scheduler feeding simt_fetch_stage; one
// instruction in flight per warp.
module simt_warp_scheduler
  import pkg_opengpu::*;
#(
  parameter int NUM_WARPS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     kill,
  input  logic                     launch_valid,
  input  logic [WARP_ID_WIDTH-1:0] launch_warp_id,
  input  logic [DATA_WIDTH-1:0]    launch_pc,
  input  logic [WARP_SIZE-1:0]     launch_mask,
  output logic                     warp_valid,
  output logic [WARP_ID_WIDTH-1:0] warp_id,
  output logic [DATA_WIDTH-1:0]    warp_pc,
  output logic [WARP_SIZE-1:0]     warp_mask,
  input  logic                     issue_ack,
  input  logic                     complete_valid,
  input  logic [WARP_ID_WIDTH-1:0] complete_warp_id,
  input  logic [DATA_WIDTH-1:0]    complete_next_pc,
  input  logic [WARP_SIZE-1:0]     complete_mask,
  input  logic                     complete_exit,
  output logic [NUM_WARPS-1:0]     active_warps,
  output logic                     all_idle,
  output logic                     proto_err,
  output logic [31:0]              issue_count
);
  warp_state_t state_q [NUM_WARPS];
  warp_state_t state_d [NUM_WARPS];
  logic [DATA_WIDTH-1:0] pc_q [NUM_WARPS];
  logic [DATA_WIDTH-1:0] pc_d [NUM_WARPS];
  logic [WARP_SIZE-1:0] mask_q [NUM_WARPS];
  logic [WARP_SIZE-1:0] mask_d [NUM_WARPS];
  logic [WARP_ID_WIDTH-1:0] rr_ptr;
  logic [WARP_ID_WIDTH-1:0] sel_id;
  logic [NUM_WARPS-1:0] req;
  logic [NUM_WARPS-1:0] gnt;
  logic any_ready;
  logic ack_ok;
  logic err_set;

  always_comb begin
    req = '0;
    active_warps = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      req[w] = (state_q[w] == READY);
      active_warps[w] = (state_q[w] != INACTIVE);
    end
  end

  rr_arbiter #(
    .W   (NUM_WARPS),
    .IDW (WARP_ID_WIDTH)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .id  (sel_id),
    .any (any_ready)
  );

  assign warp_valid = enable && !kill && any_ready;
  assign warp_id = warp_valid ? sel_id : '0;
  assign warp_pc = pc_q[warp_id];
  assign warp_mask = mask_q[warp_id];
  assign ack_ok = issue_ack && warp_valid;
  assign all_idle = (active_warps == '0);

  // Same-warp ack+complete: the offered warp is READY, so the
  // completion fails its PENDING check and the ack stands.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    mask_d = mask_q;
    err_set = issue_ack && !warp_valid;
    if (kill) begin
      for (int w = 0; w < NUM_WARPS; w++)
        state_d[w] = INACTIVE;
    end else if (enable) begin
      for (int w = 0; w < NUM_WARPS; w++)
        if (ack_ok && gnt[w])
          state_d[w] = PENDING;
      if (launch_valid) begin
        if (state_q[launch_warp_id] != INACTIVE) begin
          err_set = 1'b1;
        end else if (launch_mask == '0) begin
          err_set = 1'b1;
        end else begin
          state_d[launch_warp_id] = READY;
          pc_d[launch_warp_id] = launch_pc;
          mask_d[launch_warp_id] = launch_mask;
        end
      end
      if (complete_valid) begin
        if (state_q[complete_warp_id] != PENDING) begin
          err_set = 1'b1;
        end else if (complete_exit || complete_mask == '0) begin
          state_d[complete_warp_id] = INACTIVE;
        end else begin
          state_d[complete_warp_id] = READY;
          pc_d[complete_warp_id] = complete_next_pc;
          mask_d[complete_warp_id] = complete_mask;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= INACTIVE;
        pc_q[w] <= '0;
        mask_q[w] <= '0;
      end
      rr_ptr <= WARP_ID_WIDTH'(NUM_WARPS - 1);
      proto_err <= 1'b0;
      issue_count <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      mask_q <= mask_d;
      proto_err <= proto_err | err_set;
      if (ack_ok) begin
        rr_ptr <= sel_id;
        issue_count <= issue_count + 32'd1;
      end
    end
  end
endmodule
